// File: rtl/prio_encoder_arb.sv
// N-input priority encoder / arbiter with a registered winner, valid/ack handshake,
// and a selectable fixed-priority or round-robin mode.
module prio_encoder_arb #(
    parameter  int N  = 8,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          mode,
    input  logic [N-1:0]  req,
    input  logic          ack,
    output logic          valid,
    output logic [IW-1:0] idx,
    output logic [N-1:0]  grant,
    output logic          multi
);

    logic          valid_q, valid_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [N-1:0]  grant_q, grant_d;
    logic          multi_q, multi_d;
    logic [IW-1:0] ptr_q, ptr_d;

    logic          free;
    logic [IW-1:0] ptr_eff;
    logic [IW-1:0] fix_idx;
    logic [IW-1:0] rr_idx;
    logic          rr_found;
    logic [IW-1:0] win;
    logic          multi_c;
    logic [N-1:0]  one;
    int            j;

    always_comb begin
        free = !valid_q | ack;

        // A winner accepted on this edge moves the pointer before the new scan,
        // so back-to-back round-robin captures rotate without repeating.
        ptr_eff = ptr_q;
        if (valid_q && ack)
            ptr_eff = (idx_q == IW'(N - 1)) ? '0 : idx_q + 1'b1;

        fix_idx = '0;
        for (int i = 0; i < N; i++)
            if (req[i]) fix_idx = IW'(i);

        rr_idx   = '0;
        rr_found = 1'b0;
        j        = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr_eff) + k;
            if (j >= N) j = j - N;
            if (!rr_found && req[j]) begin
                rr_idx   = IW'(j);
                rr_found = 1'b1;
            end
        end

        win     = mode ? rr_idx : fix_idx;
        multi_c = |(req & (req - 1'b1));
        one     = {{(N-1){1'b0}}, 1'b1};

        valid_d = valid_q;
        idx_d   = idx_q;
        grant_d = grant_q;
        multi_d = multi_q;
        ptr_d   = ptr_q;

        if (free) begin
            ptr_d   = ptr_eff;
            valid_d = 1'b0;
            grant_d = '0;
            multi_d = 1'b0;
            if (en && |req) begin
                valid_d = 1'b1;
                idx_d   = win;
                grant_d = one << win;
                multi_d = multi_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            idx_q   <= '0;
            grant_q <= '0;
            multi_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            idx_q   <= idx_d;
            grant_q <= grant_d;
            multi_q <= multi_d;
            ptr_q   <= ptr_d;
        end
    end

    assign valid = valid_q;
    assign idx   = idx_q;
    assign grant = grant_q;
    assign multi = multi_q;

endmodule

// File: tb/tb_prio_encoder_arb.sv
// Bench for prio_encoder_arb: N=8 and N=5 instances checked every cycle against
// a behavioural model, with directed scenarios followed by random traffic.
module tb_prio_encoder_arb;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst8_n, en8, mode8, ack8;
    logic [7:0] req8;
    logic       valid8, multi8;
    logic [2:0] idx8;
    logic [7:0] grant8;

    logic       rst5_n, en5, mode5, ack5;
    logic [4:0] req5;
    logic       valid5, multi5;
    logic [2:0] idx5;
    logic [4:0] grant5;

    prio_encoder_arb #(.N(8)) dut8 (
        .clk(clk), .rst_n(rst8_n), .en(en8), .mode(mode8), .req(req8), .ack(ack8),
        .valid(valid8), .idx(idx8), .grant(grant8), .multi(multi8)
    );

    prio_encoder_arb #(.N(5)) dut5 (
        .clk(clk), .rst_n(rst5_n), .en(en5), .mode(mode5), .req(req5), .ack(ack5),
        .valid(valid5), .idx(idx5), .grant(grant5), .multi(multi5)
    );

    typedef struct {
        bit v;
        int idx;
        bit multi;
        int ptr;
    } mst_t;

    mst_t m8, m5;
    int   n_assert = 0;
    int   n_fail   = 0;

    // Reference: the arbiter's rules stated directly on integers.
    function automatic mst_t mstep(mst_t s, int n, bit rst, bit en, bit mode,
                                   logic [255:0] req, bit ack);
        mst_t ns;
        int   cnt;
        int   p;
        ns  = s;
        cnt = 0;
        if (rst) begin
            ns.v = 0; ns.idx = 0; ns.multi = 0; ns.ptr = 0;
            return ns;
        end
        if (s.v && !ack) return s;
        p = s.ptr;
        if (s.v) p = (s.idx + 1) % n;
        ns.ptr   = p;
        ns.v     = 0;
        ns.multi = 0;
        if (!en) return ns;
        for (int i = 0; i < n; i++) if (req[i] === 1'b1) cnt++;
        if (cnt == 0) return ns;
        ns.v     = 1;
        ns.multi = (cnt >= 2);
        if (!mode) begin
            for (int i = 0; i < n; i++) if (req[i] === 1'b1) ns.idx = i;
        end else begin
            for (int k = n - 1; k >= 0; k--) if (req[(p + k) % n] === 1'b1) ns.idx = (p + k) % n;
        end
        return ns;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [255:0] g;
        g = m8.v ? (256'd1 << m8.idx) : '0;
        chk("valid8", {255'b0, valid8}, {255'b0, m8.v});
        chk("idx8",   {253'b0, idx8},   256'(m8.idx));
        chk("grant8", {248'b0, grant8}, g);
        chk("multi8", {255'b0, multi8}, {255'b0, m8.multi});
        g = m5.v ? (256'd1 << m5.idx) : '0;
        chk("valid5", {255'b0, valid5}, {255'b0, m5.v});
        chk("idx5",   {253'b0, idx5},   256'(m5.idx));
        chk("grant5", {251'b0, grant5}, g);
        chk("multi5", {255'b0, multi5}, {255'b0, m5.multi});
    endtask

    task automatic tick();
        @(posedge clk);
        m8 = mstep(m8, 8, !rst8_n, en8, mode8, {248'b0, req8}, ack8);
        m5 = mstep(m5, 5, !rst5_n, en5, mode5, {251'b0, req5}, ack5);
        #1;
        check_all();
    endtask

    int rr_exp8[5] = '{0, 2, 7, 0, 2};
    int rr_exp5[3] = '{0, 4, 0};

    initial begin
        m8 = '{0, 0, 0, 0};
        m5 = '{0, 0, 0, 0};
        rst8_n = 0; en8 = 1; mode8 = 0; ack8 = 0; req8 = 8'hFF;
        rst5_n = 0; en5 = 0; mode5 = 0; ack5 = 0; req5 = '0;

        // 1: reset then first capture
        tick(); tick();
        chk("t1_rst_valid", {255'b0, valid8}, 256'd0);
        chk("t1_rst_grant", {248'b0, grant8}, 256'd0);
        rst8_n = 1;
        tick();
        chk("t1_idx",   {253'b0, idx8},   256'd7);
        chk("t1_grant", {248'b0, grant8}, 256'h80);
        chk("t1_multi", {255'b0, multi8}, 256'd1);

        // 2: fixed-priority single-bit walk
        ack8 = 1;
        for (int k = 0; k < 8; k++) begin
            req8 = 8'd1 << k;
            tick();
            chk("t2_walk_idx", {253'b0, idx8}, 256'(k));
            chk("t2_walk_multi", {255'b0, multi8}, 256'd0);
        end
        req8 = 8'b0010_0110;
        tick();
        chk("t2_multi_idx", {253'b0, idx8}, 256'd5);
        chk("t2_multi_flag", {255'b0, multi8}, 256'd1);

        // 3: round-robin rotation from a fresh pointer
        rst8_n = 0; tick(); rst8_n = 1;
        mode8 = 1; req8 = 8'b1000_0101; ack8 = 1; en8 = 1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t3_rr_idx", {253'b0, idx8}, 256'(rr_exp8[k]));
            chk("t3_rr_valid", {255'b0, valid8}, 256'd1);
        end

        // 4: back-pressure hold, including X on req while held
        mode8 = 0; req8 = 8'h10; ack8 = 1;
        tick();
        ack8 = 0;
        for (int k = 0; k < 5; k++) begin
            req8 = (k % 2 == 0) ? 8'h01 : 8'hxx;
            en8  = k[0];
            tick();
            chk("t4_hold_idx", {253'b0, idx8}, 256'd4);
            chk("t4_hold_grant", {248'b0, grant8}, 256'h10);
        end
        ack8 = 1; en8 = 1; req8 = 8'h01;
        tick();
        chk("t4_release_idx", {253'b0, idx8}, 256'd0);

        // 5: enable off and empty request
        en8 = 0;
        tick();
        chk("t5_en_off", {255'b0, valid8}, 256'd0);
        en8 = 1; req8 = 8'h00;
        tick();
        chk("t5_empty_valid", {255'b0, valid8}, 256'd0);
        chk("t5_empty_grant", {248'b0, grant8}, 256'd0);

        // 6: N=5 round-robin wrap, then reset during a held output
        rst5_n = 1; en5 = 1; mode5 = 1; ack5 = 1; req5 = 5'b10001;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t6_rr5_idx", {253'b0, idx5}, 256'(rr_exp5[k]));
        end
        ack5 = 0; rst5_n = 0;
        tick();
        chk("t6_rst_valid", {255'b0, valid5}, 256'd0);
        rst5_n = 1; ack5 = 1;
        tick();
        chk("t6_after_rst_idx", {253'b0, idx5}, 256'd0);

        // Random traffic on both instances
        for (int c = 0; c < 600; c++) begin
            rst8_n = ($urandom_range(0, 49) != 0);
            en8    = ($urandom_range(0, 3) != 0);
            mode8  = $urandom_range(0, 1);
            ack8   = $urandom_range(0, 1);
            req8   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            rst5_n = ($urandom_range(0, 49) != 0);
            en5    = ($urandom_range(0, 3) != 0);
            mode5  = $urandom_range(0, 1);
            ack5   = $urandom_range(0, 1);
            req5   = ($urandom_range(0, 7) == 0) ? 5'h00 : 5'($urandom);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
